// File: rtl/sram_rgb_bank.sv
// Multi-plane frame store: NUM_CH independent byte-writable RAMs sharing one
// read address, plus a sequencer that zeroes every plane one word per cycle.
module sram_rgb_bank #(
  parameter int NUM_CH         = 3,
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE_W          = DATA_W / 8,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [CH_W-1:0]          wr_ch,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [BE_W-1:0]          wr_be,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     clr_start,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
  logic              host_wr;
  logic              rd_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // clr_cnt wraps back to 0 on the last clear word, so IDLE always sees 0.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_start) state_next = CLEAR;
      end
      CLEAR: begin
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == '1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == CLEAR);
  assign host_wr   = wr_en & ~busy;
  assign rd_accept = rd_en & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_accept;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_plane
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rd_word;
      logic              plane_we;

      // Out-of-range channels never match any plane index, so they drop out here.
      assign plane_we = host_wr && (wr_ch == CH_W'(gi));

      always_ff @(posedge clk) begin
        if (busy) begin
          mem[clr_cnt] <= '0;
        end else if (plane_we) begin
          for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end

      // Separate from the write process so a same-edge write yields the old word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rd_word <= '0;
        else if (rd_accept) rd_word <= mem[rd_addr];
      end

      assign rd_data[gi*DATA_W +: DATA_W] = rd_word;
    end
  endgenerate

endmodule

// File: tb/tb_sram_rgb_bank.sv
// Self-checking bench for sram_rgb_bank: directed scenarios plus a randomized
// run, all compared against a plain array model of the three planes.
module tb_sram_rgb_bank;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int BE_W   = 4;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     wr_en;
  logic [CH_W-1:0]          wr_ch;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [BE_W-1:0]          wr_be;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     clr_start;
  logic                     busy;

  logic [DATA_W-1:0]        model [NUM_CH][DEPTH];
  logic [NUM_CH*DATA_W-1:0] exp_rd;
  int total = 0;
  int bad   = 0;

  sram_rgb_bank #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_CH*DATA_W-1:0] model_word(int a);
    logic [NUM_CH*DATA_W-1:0] w;
    for (int c = 0; c < NUM_CH; c++) w[c*DATA_W +: DATA_W] = model[c][a];
    return w;
  endfunction

  function automatic void model_write(int ch, int a, logic [DATA_W-1:0] d, logic [BE_W-1:0] be);
    if (ch < NUM_CH)
      for (int b = 0; b < BE_W; b++)
        if (be[b]) model[ch][a][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < DEPTH; a++) model[c][a] = '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_ch = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 0; rd_addr = '0; clr_start = 0;
  endtask

  task automatic do_write(int ch, int a, logic [DATA_W-1:0] d, logic [BE_W-1:0] be);
    wr_en = 1; wr_ch = CH_W'(ch); wr_addr = ADDR_W'(a); wr_data = d; wr_be = be;
    tick();
    wr_en = 0;
    model_write(ch, a, d, be);
  endtask

  task automatic read_word(int a, output logic [NUM_CH*DATA_W-1:0] data, output logic valid);
    rd_en = 1; rd_addr = ADDR_W'(a);
    tick();
    rd_en = 0;
    data = rd_data; valid = rd_valid;
  endtask

  task automatic fill_random();
    for (int c = 0; c < NUM_CH; c++)
      for (int a = 0; a < DEPTH; a++) do_write(c, a, $urandom() | 32'h1, 4'hF);
  endtask

  task automatic test_reset();
    int n;
    logic [NUM_CH*DATA_W-1:0] d;
    logic v;
    idle_inputs();
    rst_n = 0;
    repeat (3) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b expected 1", busy); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    rst_n = 1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin tick(); n++; end
    model_clear();
    total++; if (n != DEPTH) begin bad++; $display("FAIL reset_clear_len: got %0d cycles expected %0d", n, DEPTH); end
    read_word(5, d, v);
    exp_rd = model_word(5);
    total++; if (v !== 1'b1) begin bad++; $display("FAIL reset_read_valid: got %b expected 1", v); end
    total++; if (d !== '0) begin bad++; $display("FAIL reset_read_data: got %h expected 0", d); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL valid_one_cycle: got %b expected 0", rd_valid); end
    total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL hold_data: got %h expected %h", rd_data, exp_rd); end
    $display("test_reset: clear lasted %0d cycles", n);
  endtask

  task automatic test_byte_enable();
    logic [NUM_CH*DATA_W-1:0] d;
    logic v;
    do_write(1, 3, 32'hAABBCCDD, 4'b1111);
    do_write(1, 3, 32'h11223344, 4'b0101);
    read_word(3, d, v);
    exp_rd = d;
    total++; if (v !== 1'b1) begin bad++; $display("FAIL be_valid: got %b expected 1", v); end
    total++;
    if (d !== {32'h0, 32'hAA22CC44, 32'h0}) begin
      bad++; $display("FAIL be_data: got %h expected %h", d, {32'h0, 32'hAA22CC44, 32'h0});
    end
    $display("test_byte_enable: addr3 = %h", d);
  endtask

  task automatic test_read_first();
    logic [NUM_CH*DATA_W-1:0] d, pre;
    logic v;
    pre = model_word(7);
    wr_en = 1; wr_ch = 0; wr_addr = 7; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    rd_en = 1; rd_addr = 7;
    tick();
    idle_inputs();
    model_write(0, 7, 32'hDEADBEEF, 4'hF);
    total++; if (rd_data[31:0] !== 32'h0 || rd_data !== pre) begin bad++; $display("FAIL read_first_old: got %h expected %h", rd_data, pre); end
    read_word(7, d, v);
    exp_rd = d;
    total++; if (d[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL read_first_new: got %h expected deadbeef", d[31:0]); end
    $display("test_read_first: old=%h new=%h", pre[31:0], d[31:0]);
  endtask

  task automatic test_bad_channel();
    logic [NUM_CH*DATA_W-1:0] d;
    logic v;
    do_write(3, 2, 32'hFFFFFFFF, 4'hF);
    do_write(0, 2, 32'hFFFFFFFF, 4'h0);
    read_word(2, d, v);
    exp_rd = d;
    total++; if (d !== '0) begin bad++; $display("FAIL bad_channel: got %h expected 0", d); end
    $display("test_bad_channel: addr2 = %h", d);
  endtask

  task automatic test_random();
    logic [NUM_CH*DATA_W-1:0] pre;
    int we, re, ch, wa, ra;
    logic [DATA_W-1:0] dd;
    logic [BE_W-1:0] be;
    int errs0;
    errs0 = bad;
    for (int i = 0; i < 300; i++) begin
      we = $urandom_range(0, 1); re = $urandom_range(0, 1);
      ch = $urandom_range(0, 3); wa = $urandom_range(0, DEPTH-1); ra = $urandom_range(0, DEPTH-1);
      dd = $urandom(); be = BE_W'($urandom_range(0, 15));
      wr_en = we[0]; wr_ch = CH_W'(ch); wr_addr = ADDR_W'(wa); wr_data = dd; wr_be = be;
      rd_en = re[0]; rd_addr = ADDR_W'(ra);
      pre = model_word(ra);
      tick();
      if (re != 0) exp_rd = pre;
      if (we != 0) model_write(ch, wa, dd, be);
      total++; if (rd_valid !== re[0]) begin bad++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, rd_valid, re[0]); end
      total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL rand_data[%0d]: got %h expected %h", i, rd_data, exp_rd); end
    end
    idle_inputs();
    $display("test_random: 300 cycles, %0d new failures", bad - errs0);
  endtask

  task automatic test_clear_busy();
    logic [NUM_CH*DATA_W-1:0] d;
    logic v;
    int n;
    fill_random();
    read_word(0, d, v);
    exp_rd = model_word(0);
    total++; if (d !== exp_rd) begin bad++; $display("FAIL fill_read: got %h expected %h", d, exp_rd); end
    clr_start = 1;
    tick();
    clr_start = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy_start: got %b expected 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      wr_en = 1; wr_ch = CH_W'($urandom_range(0, 2)); wr_addr = ADDR_W'($urandom_range(0, DEPTH-1));
      wr_data = $urandom() | 32'h1; wr_be = 4'hF;
      rd_en = 1; rd_addr = ADDR_W'($urandom_range(0, DEPTH-1));
      clr_start = (n >= 3 && n <= 6);
      tick();
      n++;
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL busy_rd_valid[%0d]: got %b expected 0", n, rd_valid); end
      total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL busy_rd_hold[%0d]: got %h expected %h", n, rd_data, exp_rd); end
    end
    idle_inputs();
    model_clear();
    total++; if (n != DEPTH) begin bad++; $display("FAIL clear_len: got %0d cycles expected %0d", n, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, d, v);
      exp_rd = model_word(a);
      total++; if (v !== 1'b1 || d !== exp_rd) begin bad++; $display("FAIL after_clear[%0d]: got v=%b %h expected v=1 %h", a, v, d, exp_rd); end
    end
    $display("test_clear_busy: clear lasted %0d cycles", n);
  endtask

  task automatic test_reset_mid_clear();
    logic [NUM_CH*DATA_W-1:0] d;
    logic v;
    int n;
    fill_random();
    read_word(4, d, v);
    exp_rd = model_word(4);
    total++; if (d !== exp_rd) begin bad++; $display("FAIL midrst_pre_read: got %h expected %h", d, exp_rd); end
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (9) tick();
    rst_n = 0;
    #1;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b expected 0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL midrst_data: got %h expected 0", rd_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy: got %b expected 1", busy); end
    repeat (2) tick();
    rst_n = 1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin tick(); n++; end
    model_clear();
    total++; if (n != DEPTH) begin bad++; $display("FAIL midrst_clear_len: got %0d cycles expected %0d", n, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, d, v);
      exp_rd = model_word(a);
      total++; if (v !== 1'b1 || d !== exp_rd) begin bad++; $display("FAIL midrst_after[%0d]: got v=%b %h expected v=1 %h", a, v, d, exp_rd); end
    end
    $display("test_reset_mid_clear: restarted clear lasted %0d cycles", n);
  endtask

  initial begin
    exp_rd = '0;
    test_reset();
    test_byte_enable();
    test_read_first();
    test_bad_channel();
    test_random();
    test_clear_busy();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_rgb_bank.md
SRAM_RGB_BANK -- requirements
Module: sram_rgb_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of independent colour planes.
REQ-002 SHALL have parameter ADDR_W, default 14, word address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter DATA_W, default 32, word width per plane; multiple of 8.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, auto-clear all planes after reset release.
REQ-005 SHALL derive localparams BE_W = DATA_W/8 and CH_W = max(1, clog2(NUM_CH)).
REQ-006 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_ch  input  CH_W  target plane for write.
REQ-010 SHALL have port wr_addr  input  ADDR_W  write word address.
REQ-011 SHALL have port wr_data  input  DATA_W  write data.
REQ-012 SHALL have port wr_be  input  BE_W  byte enables; bit i covers wr_data[8i+7:8i].
REQ-013 SHALL have port rd_en  input  1  read request, all planes in parallel.
REQ-014 SHALL have port rd_addr  input  ADDR_W  read word address.
REQ-015 SHALL have port rd_data  output  NUM_CH*DATA_W  plane c at bits [c*DATA_W +: DATA_W].
REQ-016 SHALL have port rd_valid  output  1  rd_data updated this cycle.
REQ-017 SHALL have port clr_start  input  1  request a full clear of all planes.
REQ-018 SHALL have port busy  output  1  clear in progress; host accesses ignored.

Function
REQ-019 SHALL hold NUM_CH arrays of DEPTH x DATA_W, one write port and one read port each.
REQ-020 SHALL, when wr_en=1, busy=0, wr_ch<NUM_CH, write only the bytes of mem[wr_ch][wr_addr] whose wr_be bit is 1, at the clock edge.
REQ-021 SHALL ignore writes with wr_ch>=NUM_CH or wr_be=0; no plane is modified.
REQ-022 SHALL, when rd_en=1 and busy=0, register all planes' words at rd_addr into rd_data at the next edge; latency 1 cycle.
REQ-023 SHALL assert rd_valid for exactly the cycle after an accepted read; 0 otherwise.
REQ-024 SHALL hold rd_data unchanged when no read is accepted.
REQ-025 SHALL be read-first: same-cycle read and write to the same address return the pre-write word.
REQ-026 SHALL implement FSM states IDLE and CLEAR.
REQ-027 SHALL transition IDLE->CLEAR when clr_start=1; clr_start while in CLEAR is ignored.
REQ-028 SHALL, in CLEAR, write zero to address clr_cnt of every plane each cycle, clr_cnt counting 0..DEPTH-1.
REQ-029 SHALL transition CLEAR->IDLE after writing address DEPTH-1; clear lasts exactly DEPTH cycles.
REQ-030 SHALL drive busy=1 iff state is CLEAR (registered, no combinational path from clr_start).
REQ-031 SHALL ignore host wr_en and rd_en while busy=1; rd_valid stays 0.
REQ-032 SHALL accept host accesses in the first cycle busy=0 after a clear.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously set rd_data=0, rd_valid=0, clr_cnt=0.
REQ-034 SHALL, on rst_n=0, set state CLEAR (busy=1) if CLEAR_ON_RESET=1, else IDLE (busy=0).
REQ-035 SHALL not reset memory contents directly; contents change only via writes or clear.
REQ-036 SHALL, on reset asserted mid-clear, restart the clear at address 0 after release (CLEAR_ON_RESET=1) or abandon it (CLEAR_ON_RESET=0).

Verification (bench uses NUM_CH=3, ADDR_W=4, DATA_W=32)
REQ-037 Release reset, CLEAR_ON_RESET=1 -> busy=1 for 16 cycles then 0; reading addr 5 returns all planes 0x00000000, rd_valid one cycle after rd_en.
REQ-038 Write ch1 addr 3 data 0xAABBCCDD be=4'b1111, then ch1 addr 3 data 0x11223344 be=4'b0101 -> read addr 3 plane1 = 0xAA22CC44, planes 0 and 2 = 0.
REQ-039 Same cycle write ch0 addr 7 0xDEADBEEF and read addr 7 -> rd_data plane0 = old value 0; next read returns 0xDEADBEEF.
REQ-040 Write with wr_ch=3 addr 2 0xFFFFFFFF -> all planes addr 2 remain 0.
REQ-041 Fill addr 0..15, pulse clr_start, issue writes/reads during busy -> no rd_valid, no writes; after 16 cycles all addresses read 0.
REQ-042 Assert rst_n=0 at clr_cnt=9 for 2 cycles -> rd_valid=0 immediately; after release busy=1 for a full 16 cycles from addr 0.
